// File: rtl/multimode_ff_bank.sv
// WIDTH-bit register with a run-time mode (D/T/JK/SR), illegal-SR detection, sticky flag and saturating counter.
// One-cycle latency on every output; no handshake, inputs are sampled on every rising edge.
module multimode_ff_bank #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             mode_ld,
    input  logic [1:0]       mode_in,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             err_clr,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qn_bar,
    output logic [1:0]       mode,
    output logic             sr_err,
    output logic [CNT_W-1:0] err_cnt
);

    typedef enum logic [1:0] {
        MODE_D  = 2'b00,
        MODE_T  = 2'b01,
        MODE_JK = 2'b10,
        MODE_SR = 2'b11
    } mode_t;

    logic [WIDTH-1:0] q_q, q_d;
    mode_t            mode_q, mode_d;
    logic             sr_err_q, sr_err_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic             illegal;

    assign illegal = en && (mode_q == MODE_SR) && (|(a & b));

    always_comb begin
        q_d = q_q;
        if (en) begin
            case (mode_q)
                MODE_D:  q_d = a;
                MODE_T:  q_d = q_q ^ a;
                MODE_JK: q_d = (a & ~q_q) | (~b & q_q);
                // a==b holds (covers the illegal 1/1 case); otherwise a wins
                MODE_SR: q_d = (q_q & ~(a ^ b)) | (a & ~b);
                default: q_d = q_q;
            endcase
        end
    end

    always_comb begin
        mode_d = mode_q;
        if (mode_ld) begin
            mode_d = mode_t'(mode_in);
        end
    end

    // An illegal event on the same edge as err_clr takes precedence over the clear
    always_comb begin
        sr_err_d  = sr_err_q;
        err_cnt_d = err_cnt_q;
        if (illegal) begin
            sr_err_d = 1'b1;
            if (err_clr) begin
                err_cnt_d = {{(CNT_W-1){1'b0}}, 1'b1};
            end else if (!(&err_cnt_q)) begin
                err_cnt_d = err_cnt_q + 1'b1;
            end
        end else if (err_clr) begin
            sr_err_d  = 1'b0;
            err_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_q       <= '0;
            mode_q    <= MODE_D;
            sr_err_q  <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            q_q       <= q_d;
            mode_q    <= mode_d;
            sr_err_q  <= sr_err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign q       = q_q;
    assign qn_bar  = ~q_q;
    assign mode    = mode_q;
    assign sr_err  = sr_err_q;
    assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_multimode_ff_bank.sv
// Directed bench: two instances (8-bit and 2-bit error counter) share one stimulus stream.
module tb_multimode_ff_bank;

    logic       clk = 1'b0;
    logic       rst_n, en, mode_ld, err_clr;
    logic [1:0] mode_in;
    logic [3:0] a, b;

    logic [3:0] q, qn_bar, q2, qn_bar2;
    logic [1:0] mode, mode2;
    logic       sr_err, sr_err2;
    logic [7:0] err_cnt;
    logic [1:0] err_cnt2;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    multimode_ff_bank #(.WIDTH(4), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .mode_ld(mode_ld), .mode_in(mode_in),
        .a(a), .b(b), .err_clr(err_clr),
        .q(q), .qn_bar(qn_bar), .mode(mode), .sr_err(sr_err), .err_cnt(err_cnt)
    );

    multimode_ff_bank #(.WIDTH(4), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode_ld(mode_ld), .mode_in(mode_in),
        .a(a), .b(b), .err_clr(err_clr),
        .q(q2), .qn_bar(qn_bar2), .mode(mode2), .sr_err(sr_err2), .err_cnt(err_cnt2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [3:0] eq, input logic [1:0] emode,
                             input logic eerr, input logic [7:0] ecnt, input logic [1:0] ecnt2);
        logic [3:0] eqn;
        eqn = ~eq;
        chk({tag, ".q"}, {28'd0, q}, {28'd0, eq});
        chk({tag, ".qn_bar"}, {28'd0, qn_bar}, {28'd0, eqn});
        chk({tag, ".mode"}, {30'd0, mode}, {30'd0, emode});
        chk({tag, ".sr_err"}, {31'd0, sr_err}, {31'd0, eerr});
        chk({tag, ".err_cnt"}, {24'd0, err_cnt}, {24'd0, ecnt});
        chk({tag, ".q_c2"}, {28'd0, q2}, {28'd0, eq});
        chk({tag, ".qn_bar_c2"}, {28'd0, qn_bar2}, {28'd0, eqn});
        chk({tag, ".sr_err_c2"}, {31'd0, sr_err2}, {31'd0, eerr});
        chk({tag, ".err_cnt_c2"}, {30'd0, err_cnt2}, {30'd0, ecnt2});
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; mode_ld = 1'b0; mode_in = 2'b00;
        a = 4'h0; b = 4'h0; err_clr = 1'b0;

        // Reset, then D mode
        step(); step();
        check_all("reset", 4'h0, 2'b00, 1'b0, 8'd0, 2'd0);
        rst_n = 1'b1; en = 1'b1; a = 4'b1010;
        step();
        check_all("d_load", 4'b1010, 2'b00, 1'b0, 8'd0, 2'd0);

        // Switch to T on the same edge: D still applies, a=0 clears q
        mode_ld = 1'b1; mode_in = 2'b01; a = 4'b0000;
        step();
        check_all("to_t", 4'b0000, 2'b01, 1'b0, 8'd0, 2'd0);
        mode_ld = 1'b0; a = 4'b0011;
        step(); check_all("t_1", 4'b0011, 2'b01, 1'b0, 8'd0, 2'd0);
        step(); check_all("t_2", 4'b0000, 2'b01, 1'b0, 8'd0, 2'd0);
        step(); check_all("t_3", 4'b0011, 2'b01, 1'b0, 8'd0, 2'd0);

        // Back to D (T toggles 0011 -> 0000 on the switch edge), then q=0101
        mode_ld = 1'b1; mode_in = 2'b00;
        step(); check_all("to_d", 4'b0000, 2'b00, 1'b0, 8'd0, 2'd0);
        mode_ld = 1'b0; a = 4'b0101;
        step(); check_all("d_0101", 4'b0101, 2'b00, 1'b0, 8'd0, 2'd0);

        // JK loaded on the same edge as a D update
        mode_ld = 1'b1; mode_in = 2'b10; a = 4'b1111; b = 4'b0000;
        step(); check_all("to_jk", 4'b1111, 2'b10, 1'b0, 8'd0, 2'd0);
        mode_ld = 1'b0; a = 4'b1111; b = 4'b1111;
        step(); check_all("jk_toggle", 4'b0000, 2'b10, 1'b0, 8'd0, 2'd0);
        a = 4'b1100; b = 4'b1010;
        step(); check_all("jk_mix", 4'b1100, 2'b10, 1'b0, 8'd0, 2'd0);

        // To SR: JK clears all bits on the switch edge
        mode_ld = 1'b1; mode_in = 2'b11; a = 4'b0000; b = 4'b1111;
        step(); check_all("to_sr", 4'b0000, 2'b11, 1'b0, 8'd0, 2'd0);
        mode_ld = 1'b0; a = 4'b1100; b = 4'b0101;
        step(); check_all("sr_partial", 4'b1000, 2'b11, 1'b1, 8'd1, 2'd1);

        // Clear, then saturation
        err_clr = 1'b1; a = 4'b0000; b = 4'b0000;
        step(); check_all("clr", 4'b1000, 2'b11, 1'b0, 8'd0, 2'd0);
        err_clr = 1'b0; a = 4'b0001; b = 4'b0001;
        step(); check_all("sat_1", 4'b1000, 2'b11, 1'b1, 8'd1, 2'd1);
        step(); check_all("sat_2", 4'b1000, 2'b11, 1'b1, 8'd2, 2'd2);
        step(); check_all("sat_3", 4'b1000, 2'b11, 1'b1, 8'd3, 2'd3);
        step(); check_all("sat_4", 4'b1000, 2'b11, 1'b1, 8'd4, 2'd3);
        step(); check_all("sat_5", 4'b1000, 2'b11, 1'b1, 8'd5, 2'd3);
        err_clr = 1'b1;
        step(); check_all("clr_vs_evt", 4'b1000, 2'b11, 1'b1, 8'd1, 2'd1);
        a = 4'b0000; b = 4'b0000;
        step(); check_all("clr_quiet", 4'b1000, 2'b11, 1'b0, 8'd0, 2'd0);

        // Enable gating
        err_clr = 1'b0; a = 4'b1111; b = 4'b1111;
        step(); check_all("evt_before_gate", 4'b1000, 2'b11, 1'b1, 8'd1, 2'd1);
        en = 1'b0;
        step(); check_all("gate_illegal", 4'b1000, 2'b11, 1'b1, 8'd1, 2'd1);
        a = 4'b0011; b = 4'b0000;
        step(); check_all("gate_set", 4'b1000, 2'b11, 1'b1, 8'd1, 2'd1);
        en = 1'b1;
        step(); check_all("sr_set", 4'b1011, 2'b11, 1'b1, 8'd1, 2'd1);

        // Reset overrides enable, mode load and a pending illegal input
        rst_n = 1'b0; mode_ld = 1'b1; mode_in = 2'b10; a = 4'b1111; b = 4'b1111;
        step(); check_all("reset_prio", 4'b0000, 2'b00, 1'b0, 8'd0, 2'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/multimode_ff_bank.md
# multimode_ff_bank

Parametrised bank of WIDTH edge-triggered flip-flops. All bits share one run-time mode: D, T, JK or SR. It generalises the single SR-from-JK flip-flop to a multi-bit, mode-selectable register. It adds enable, a loadable mode register, and illegal-SR-input detection with a sticky flag and a saturating event counter. It sits in the sequential-primitives layer and serves as a drop-in state register for the counters and FSMs built on top of it.

## Interface
- WIDTH, 4, number of flip-flop bits (≥1)
- CNT_W, 8, width of the illegal-SR event counter (≥2)

- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- en  input  1  bit-update enable
- mode_ld  input  1  load mode_in into mode register
- mode_in  input  2  00=D, 01=T, 10=JK, 11=SR
- a  input  WIDTH  per-bit D / T / J / S input
- b  input  WIDTH  per-bit K / R input; ignored in D and T modes
- err_clr  input  1  clear sr_err and err_cnt
- q  output  WIDTH  flip-flop state
- qn_bar  output  WIDTH  always bitwise ~q
- mode  output  2  current mode register
- sr_err  output  1  sticky: an illegal SR combination has been seen
- err_cnt  output  CNT_W  saturating count of illegal-SR cycles

## Operation
- Reset: the design has one clock, and its reset is synchronous and active-low. When rst_n=0 at a rising edge, the bank sets q=0, qn_bar=all ones, mode=00 (D), sr_err=0 and err_cnt=0. rst_n overrides every other input, including mid-operation.
- Mode register: on an edge with mode_ld=1, mode takes mode_in. This happens regardless of en.
- Bit update: on an edge with en=1, every bit i updates according to the mode value held before that edge. If mode_ld=1 and en=1 arrive together, the bits use the old mode and the new mode applies from the next edge.
  - D: q[i] takes a[i].
  - T: q[i] inverts when a[i]=1, otherwise holds.
  - JK: a=0,b=0 holds; a=0,b=1 clears to 0; a=1,b=0 sets to 1; a=1,b=1 inverts.
  - SR: a=0,b=0 holds; a=0,b=1 clears; a=1,b=0 sets; a=1,b=1 is illegal and that bit holds. Legal bits in the same cycle still update normally.
- en=0: q holds and no error is detected.
- Illegal event: occurs on an edge where en=1, mode=11 and at least one bit has a=b=1.
  - sr_err is set to 1.
  - err_cnt increments by 1 per cycle, not per bit.
  - err_cnt saturates at 2^CNT_W−1 and does not wrap.
- err_clr=1: sr_err goes to 0 and err_cnt goes to 0. If an illegal event occurs on the same edge, the event wins: sr_err=1 and err_cnt=1.

## Timing
- All outputs are registered. They change only on the rising edge of clk.
- Latency is one cycle from sampled inputs to q, mode, sr_err and err_cnt.
- qn_bar is the complement of the q register. It has no extra cycle of delay, so ~q == qn_bar holds every cycle.
- The block has no handshake. Inputs are sampled on every rising edge.

## Test plan
- Reset then D mode: hold rst_n=0 for 2 edges, then check q=0000, qn_bar=1111, mode=00 and err_cnt=0. Apply en=1 with a=1010; after 1 edge, q=1010 and qn_bar=0101.
- T mode toggle: load mode=01 and set q=0000. Apply en=1 with a=0011 for 3 edges; q sequence is 0011, 0000, 0011.
- JK with a mode switch on the same edge: start with q=0101 in D mode. Apply mode_ld=1, mode_in=10, en=1, a=1111. After that edge, q=1111 because D was still active, and mode=10. Then apply a=1111, b=1111; after the next edge, q=0000.
- SR partial illegal: set mode=11 and q=0000. Apply a=1100, b=0101. After the edge:
  - bit 3 is set to 1.
  - bit 2 is illegal and holds 0.
  - bit 0 is reset to 0.
  - bit 1 holds 0.
  - So q=1000, sr_err=1 and err_cnt=1.
- Saturation and clear: set CNT_W=2 and hold SR mode with a=b=0001 for 5 edges. err_cnt reads 1, 2, 3, 3, 3. Then assert err_clr with the illegal input still present: err_cnt=1 and sr_err=1. Remove the illegal input and assert err_clr: err_cnt=0 and sr_err=0.
- Enable gating and reset priority: in SR mode with a=b=1111 and en=0, check that q holds and err_cnt is unchanged. Then apply rst_n=0 together with en=1, mode_ld=1 and err_clr=0; the next edge gives reset values, including mode=00.
